// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access-type
// codes and the store lane / boundary-crossing helpers used at request accept.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only take the signed-size codes; loads also accept the unsigned ones.
    function automatic logic f3_legal(input logic [2:0] f3, input logic store);
        logic base;
        base = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (store)
            return base;
        return base || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic crosses(input logic [1:0] size, input logic [1:0] off);
        return ((size == 2'b01) && (off == 2'b11)) ||
               ((size == 2'b10) && (off != 2'b00));
    endfunction

    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] m;
        case (size)
            2'b00:   m = 8'b0000_0001;
            2'b01:   m = 8'b0000_0011;
            default: m = 8'b0000_1111;
        endcase
        return m << off;
    endfunction

    function automatic logic [63:0] lane_data(input logic [31:0] wdata, input logic [1:0] off);
        return {32'b0, wdata} << {off, 3'b000};
    endfunction

endpackage

// File: rtl/load_extend.sv
// Aligns a (possibly two-word) load to byte 0, truncates it to the access
// size and sign- or zero-extends the result to 32 bits.
module load_extend
    import lsu_pkg::*;
(
    input  logic [63:0] data,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    assign shifted = 32'(data >> {off, 3'b000});

    always_comb begin
        result = '0;
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    result = shifted;
            F3_BU:   result = {24'b0, shifted[7:0]};
            F3_HU:   result = {16'b0, shifted[15:0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Core-side load/store unit: splits misaligned accesses into up to two
// word-aligned bus transactions and merges/extends load data on completion.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [2:0]        funct3,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              done,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_be,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    lsu_state_t  state;
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;
    logic        store_q;
    logic        cross_q;
    logic [31:0] wdata_hi_q;
    logic [3:0]  be_hi_q;
    logic [31:0] lo_q;

    logic        req;
    logic        ack;
    logic [63:0] in_lanes;
    logic [7:0]  in_mask;
    logic [31:0] ext_lo;
    logic [31:0] load_result;

    assign req      = rd_en | wr_en;
    assign ack      = bus_ack & bus_req;
    assign in_lanes = lane_data(wdata, addr[1:0]);
    assign in_mask  = lane_mask(funct3[1:0], addr[1:0]);

    assign stall = ((state == IDLE) && req) || (state == ACC0) || (state == ACC1);

    // An aligned load completes in ACC0, so the live bus word is the low word there.
    assign ext_lo = (state == ACC1) ? lo_q : bus_rdata;

    load_extend u_load_extend (
        .data   ({bus_rdata, ext_lo}),
        .off    (off_q),
        .funct3 (funct3_q),
        .result (load_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_be     <= '0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            rdata      <= '0;
            done       <= 1'b0;
            off_q      <= '0;
            funct3_q   <= '0;
            store_q    <= 1'b0;
            cross_q    <= 1'b0;
            wdata_hi_q <= '0;
            be_hi_q    <= '0;
            lo_q       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        off_q      <= addr[1:0];
                        funct3_q   <= funct3;
                        store_q    <= wr_en;
                        cross_q    <= crosses(funct3[1:0], addr[1:0]);
                        wdata_hi_q <= in_lanes[63:32];
                        be_hi_q    <= wr_en ? in_mask[7:4] : 4'b0000;
                        if (f3_legal(funct3, wr_en)) begin
                            state     <= ACC0;
                            bus_req   <= 1'b1;
                            bus_we    <= wr_en;
                            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            bus_wdata <= in_lanes[31:0];
                            bus_be    <= wr_en ? in_mask[3:0] : 4'b0000;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ACC0: begin
                    if (ack) begin
                        lo_q <= bus_rdata;
                        if (cross_q) begin
                            state     <= ACC1;
                            bus_addr  <= bus_addr + ADDR_W'(4);
                            bus_wdata <= wdata_hi_q;
                            bus_be    <= be_hi_q;
                        end else begin
                            state   <= DONE;
                            done    <= 1'b1;
                            bus_req <= 1'b0;
                            bus_we  <= 1'b0;
                            bus_be  <= '0;
                            if (!store_q)
                                rdata <= load_result;
                        end
                    end
                end
                ACC1: begin
                    if (ack) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        bus_be  <= '0;
                        if (!store_q)
                            rdata <= load_result;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
